// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR filter: FSM encoding,
// accumulator sizing and saturation limits.
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } fir_state_e;

    // Worst-case sum of N full-precision products never overflows this width
    function automatic int unsigned fir_acc_w(input int unsigned data_w,
                                              input int unsigned coef_w,
                                              input int unsigned n_taps);
        return data_w + coef_w + $clog2(n_taps);
    endfunction

    function automatic longint fir_sat_max(input int unsigned data_w);
        return (longint'(1) <<< (data_w - 1)) - longint'(1);
    endfunction

    function automatic longint fir_sat_min(input int unsigned data_w);
        return -(longint'(1) <<< (data_w - 1));
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational output scaling: round half up, arithmetic shift, then
// saturate the accumulator to the output sample range.
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int unsigned ACC_W     = 19,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned OUT_SHIFT = 0
) (
    input  logic signed [ACC_W-1:0]  acc_i,
    output logic signed [DATA_W-1:0] data_c,
    output logic                     sat_c
);

    // One guard bit so adding the rounding constant cannot wrap
    localparam int unsigned EXT_W = ACC_W + 1;
    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'(fir_sat_max(DATA_W));
    localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'(fir_sat_min(DATA_W));

    logic signed [EXT_W-1:0] ext_c;
    logic signed [EXT_W-1:0] scaled_c;

    assign ext_c = EXT_W'(acc_i);

    generate
        if (OUT_SHIFT > 0) begin : g_round
            localparam logic signed [EXT_W-1:0] HALF =
                EXT_W'(longint'(1) <<< (OUT_SHIFT - 1));
            logic signed [EXT_W-1:0] rounded_c;
            assign rounded_c = ext_c + HALF;
            assign scaled_c  = rounded_c >>> OUT_SHIFT;
        end else begin : g_pass
            assign scaled_c = ext_c;
        end
    endgenerate

    always_comb begin
        data_c = scaled_c[DATA_W-1:0];
        sat_c  = 1'b0;
        if (scaled_c > SAT_MAX) begin
            data_c = SAT_MAX[DATA_W-1:0];
            sat_c  = 1'b1;
        end else if (scaled_c < SAT_MIN) begin
            data_c = SAT_MIN[DATA_W-1:0];
            sat_c  = 1'b1;
        end
    end

endmodule

// File: rtl/fir_mac_filter.sv
// Time-multiplexed FIR filter with a single MAC, programmable coefficients
// and valid/ready handshakes on input and output.
module fir_mac_filter
    import fir_pkg::*;
#(
    parameter int unsigned N_TAPS    = 5,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned COEF_W    = 8,
    parameter int unsigned ACC_W     = fir_acc_w(DATA_W, COEF_W, N_TAPS),
    parameter int unsigned OUT_SHIFT = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [DATA_W-1:0]   in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [DATA_W-1:0]   out_data,
    output logic                       out_sat,
    input  logic                       coef_we,
    input  logic [$clog2(N_TAPS)-1:0]  coef_addr,
    input  logic signed [COEF_W-1:0]   coef_wdata,
    output logic                       busy
);

    localparam int unsigned ADDR_W = $clog2(N_TAPS);
    localparam int unsigned PROD_W = DATA_W + COEF_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_TAPS - 1);

    fir_state_e                state_q;
    logic signed [DATA_W-1:0]  hist_q [N_TAPS];
    logic signed [COEF_W-1:0]  coef_q [N_TAPS];
    logic signed [ACC_W-1:0]   acc_q;
    logic [ADDR_W-1:0]         idx_q;
    logic                      done_q;
    logic                      in_ready_q;
    logic                      busy_q;
    logic                      out_valid_q;
    logic signed [DATA_W-1:0]  out_data_q;
    logic                      out_sat_q;

    logic signed [PROD_W-1:0]  prod_c;
    logic signed [DATA_W-1:0]  rnd_data_c;
    logic                      rnd_sat_c;
    logic                      coef_addr_ok_c;

    assign prod_c         = PROD_W'(hist_q[idx_q]) * PROD_W'(coef_q[idx_q]);
    assign coef_addr_ok_c = (32'(coef_addr) < N_TAPS);

    fir_round_sat #(
        .ACC_W     (ACC_W),
        .DATA_W    (DATA_W),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_round_sat (
        .acc_i  (acc_q),
        .data_c (rnd_data_c),
        .sat_c  (rnd_sat_c)
    );

    // FSM, history, coefficient file and MAC datapath; done_q marks the
    // extra cycle that loads the output register after the last tap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            for (int k = 0; k < int'(N_TAPS); k++) begin
                hist_q[k] <= '0;
                coef_q[k] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (coef_we && coef_addr_ok_c) begin
                        coef_q[coef_addr] <= coef_wdata;
                    end
                    if (in_valid) begin
                        hist_q[0] <= in_data;
                        for (int k = 1; k < int'(N_TAPS); k++) begin
                            hist_q[k] <= hist_q[k-1];
                        end
                        acc_q      <= '0;
                        idx_q      <= '0;
                        done_q     <= 1'b0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (done_q) begin
                        out_data_q  <= rnd_data_c;
                        out_sat_q   <= rnd_sat_c;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_OUT;
                    end else begin
                        acc_q <= acc_q + ACC_W'(prod_c);
                        if (idx_q == LAST_IDX) begin
                            done_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + ADDR_W'(1);
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_fir_mac_filter.sv
// Directed bench for fir_mac_filter: a vector table for the arithmetic cases
// plus hand sequences for backpressure, same-cycle write and mid-MAC reset.
module tb_fir_mac_filter;

    localparam int LATENCY = 6;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic signed [7:0] in_data;
    logic              out_ready;
    logic              coef_we;
    logic [2:0]        coef_addr;
    logic signed [7:0] coef_wdata;

    logic              in_ready0, out_valid0, out_sat0, busy0;
    logic signed [7:0] out_data0;
    logic              in_ready1, out_valid1, out_sat1, busy1;
    logic signed [7:0] out_data1;

    int n_pass  = 0;
    int n_total = 0;

    fir_mac_filter #(.N_TAPS(5), .DATA_W(8), .COEF_W(8), .OUT_SHIFT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_sat(out_sat0), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_wdata(coef_wdata), .busy(busy0)
    );

    fir_mac_filter #(.N_TAPS(5), .DATA_W(8), .COEF_W(8), .OUT_SHIFT(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_sat(out_sat1), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_wdata(coef_wdata), .busy(busy1)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                rst;
        bit                load;
        logic [39:0]       coefs;
        logic signed [7:0] x;
        bit                use_shift;
        int                exp_y;
        int                exp_sat;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input bit rst, input bit load, input logic [39:0] coefs,
                                    input int x, input bit use_shift,
                                    input int exp_y, input int exp_sat);
        vec_t v;
        v.rst = rst; v.load = load; v.coefs = coefs; v.x = 8'(x);
        v.use_shift = use_shift; v.exp_y = exp_y; v.exp_sat = exp_sat;
        vecs.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic apply_reset();
        in_valid  = 1'b0;
        coef_we   = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", int'(out_valid0), 0);
        chk("rst_in_ready",  int'(in_ready0), 1);
        chk("rst_busy",      int'(busy0), 0);
        chk("rst_out_data",  int'(out_data0), 0);
        chk("rst_out_sat",   int'(out_sat0), 0);
        chk("rst_shift_dut", int'({out_valid1, in_ready1, busy1}), 2);
    endtask

    task automatic write_coef(input int addr, input logic [7:0] val);
        coef_we    = 1'b1;
        coef_addr  = 3'(addr);
        coef_wdata = val;
        step();
        coef_we = 1'b0;
    endtask

    // Accept one sample, wait (bounded) for out_valid, capture, then hand off
    task automatic send_sample(input logic signed [7:0] x, output int lat,
                               output int y0, output int s0,
                               output int y1, output int s1);
        chk("pre_in_ready", int'(in_ready0), 1);
        in_data  = x;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        coef_we  = 1'b0;
        lat = 0;
        while (!out_valid0 && lat < 20) begin
            step();
            lat++;
        end
        y0 = int'(out_data0);
        s0 = int'(out_sat0);
        y1 = int'(out_data1);
        s1 = int'(out_sat1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, y0, s0, y1, s1;
        clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;

        // Impulse response, coefficients -4,-2,-1,0,0
        add_vec(1, 1, 40'h00_00_FF_FE_FC,  1, 0, -4, 0);
        add_vec(0, 0, 40'h0,               0, 0, -2, 0);
        add_vec(0, 0, 40'h0,               0, 0, -1, 0);
        add_vec(0, 0, 40'h0,               0, 0,  0, 0);
        add_vec(0, 0, 40'h0,               0, 0,  0, 0);
        // Positive saturation
        add_vec(1, 1, 40'h7F_7F_7F_7F_7F, 127, 0, 127, 1);
        for (int k = 0; k < 4; k++) add_vec(0, 0, 40'h0, 127, 0, 127, 1);
        // Negative exact limit, then clipped
        add_vec(1, 1, 40'h00_00_00_00_80,  1, 0, -128, 0);
        add_vec(0, 0, 40'h0,               2, 0, -128, 1);
        // Rounding with OUT_SHIFT=2
        add_vec(1, 1, 40'h00_00_00_00_01,  6, 1,  2, 0);
        add_vec(0, 0, 40'h0,              -6, 1, -1, 0);
        add_vec(0, 0, 40'h0,               5, 1,  1, 0);
        add_vec(0, 0, 40'h0,              -2, 1,  0, 0);
        add_vec(0, 0, 40'h0,              -7, 1, -2, 0);

        foreach (vecs[i]) begin
            if (vecs[i].rst) apply_reset();
            if (vecs[i].load) begin
                for (int k = 0; k < 5; k++) write_coef(k, vecs[i].coefs[8*k +: 8]);
            end
            send_sample(vecs[i].x, lat, y0, s0, y1, s1);
            chk($sformatf("vec%0d_latency", i), lat, LATENCY);
            chk($sformatf("vec%0d_y", i),   vecs[i].use_shift ? y1 : y0, vecs[i].exp_y);
            chk($sformatf("vec%0d_sat", i), vecs[i].use_shift ? s1 : s0, vecs[i].exp_sat);
        end

        // Backpressure with a coefficient write attempted while held in OUT
        apply_reset();
        write_coef(0, 8'd3);
        send_sample(8'sd0, lat, y0, s0, y1, s1);
        in_data  = 8'sd1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid0 && lat < 20) begin
            step();
            lat++;
        end
        chk("bp_latency", lat, LATENCY);
        coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 8'sd5;
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("bp%0d_valid", c),    int'(out_valid0), 1);
            chk($sformatf("bp%0d_data", c),     int'(out_data0), 3);
            chk($sformatf("bp%0d_in_ready", c), int'(in_ready0), 0);
            chk($sformatf("bp%0d_busy", c),     int'(busy0), 1);
        end
        coef_we   = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release_valid", int'(out_valid0), 0);
        chk("bp_release_busy",  int'(busy0), 0);
        send_sample(8'sd1, lat, y0, s0, y1, s1);
        chk("bp_locked_coef_y", y0, 3);

        // Coefficient write in the accept cycle applies to that sample
        apply_reset();
        coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 8'sd7;
        send_sample(8'sd2, lat, y0, s0, y1, s1);
        chk("same_cycle_latency", lat, LATENCY);
        chk("same_cycle_y", y0, 14);

        // Out-of-range coefficient address is ignored
        coef_we = 1'b1; coef_addr = 3'd5; coef_wdata = 8'sd9;
        send_sample(8'sd0, lat, y0, s0, y1, s1);
        chk("bad_addr_y", y0, 0);

        // Reset three cycles into MAC abandons the sample and clears state
        apply_reset();
        write_coef(0, 8'd10);
        in_data  = 8'sd1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid0), 0);
        chk("midrst_busy",      int'(busy0), 0);
        step(); step();
        rst_n = 1'b1;
        #1;
        chk("midrst_in_ready", int'(in_ready0), 1);
        chk("midrst_no_output", int'(out_valid0), 0);
        send_sample(8'sd3, lat, y0, s0, y1, s1);
        chk("midrst_latency", lat, LATENCY);
        chk("midrst_cleared_y", y0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
